// File: rtl/aes_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : aes_pkg
//  Purpose : Shared widths, word-index type and block-to-word helper for
//            the AES result collector and its FIFO.
//  Contents: AES_BLOCK_W, AES_WORD_W, AES_WORDS_PER_BLOCK, word_idx_t,
//            c_LAST_WORD, block_word()
//  Revision: 1.0  initial release
// ============================================================================
package aes_pkg;

    localparam int AES_BLOCK_W         = 128;
    localparam int AES_WORD_W          = 32;
    localparam int AES_WORDS_PER_BLOCK = 4;

    typedef logic [1:0] word_idx_t;

    localparam word_idx_t c_LAST_WORD = word_idx_t'(AES_WORDS_PER_BLOCK - 1);

    // Word 0 is the most-significant 32 bits of the block.
    function automatic logic [AES_WORD_W-1:0] block_word(
        input logic [AES_BLOCK_W-1:0] blk,
        input word_idx_t              idx
    );
        logic [AES_WORD_W-1:0] w_sel;
        w_sel = blk[127:96];
        case (idx)
            2'd0:    w_sel = blk[127:96];
            2'd1:    w_sel = blk[95:64];
            2'd2:    w_sel = blk[63:32];
            default: w_sel = blk[31:0];
        endcase
        return w_sel;
    endfunction

endpackage
`default_nettype wire

// File: rtl/aes_result_fifo.sv
`default_nettype none
// ============================================================================
//  Module  : aes_result_fifo
//  Purpose : Block-wide FIFO holding AES result blocks. A push into a full
//            FIFO is accepted only when a pop happens in the same cycle.
//  Ports   : clk, reset (async, active-high), i_clear (sync flush),
//            i_push / i_wdata  - write request and block
//            i_pop             - free the head entry
//            o_push_ok         - push accepted this cycle
//            o_rdata           - head block
//            o_count           - stored blocks
//            o_count_next      - count after this cycle's push/pop/clear
//  Revision: 1.0  initial release
// ============================================================================
module aes_result_fifo
    import aes_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   i_clear,
    input  logic                   i_push,
    input  logic [AES_BLOCK_W-1:0] i_wdata,
    input  logic                   i_pop,
    output logic                   o_push_ok,
    output logic [AES_BLOCK_W-1:0] o_rdata,
    output logic [CNT_W-1:0]       o_count,
    output logic [CNT_W-1:0]       o_count_next
);

    localparam int               PTR_W        = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] c_FULL_COUNT = CNT_W'(DEPTH);

    logic [AES_BLOCK_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]       r_head;
    logic [PTR_W-1:0]       r_tail;
    logic [CNT_W-1:0]       r_count;
    logic [CNT_W-1:0]       w_count_next;
    logic                   w_full;
    logic                   w_pop_ok;
    logic                   w_push_ok;

    assign w_full    = (r_count == c_FULL_COUNT);
    assign w_pop_ok  = i_pop & ~i_clear & (r_count != '0);
    // When full, the slot being freed by a same-cycle pop is the tail slot.
    assign w_push_ok = i_push & ~i_clear & (~w_full | w_pop_ok);

    always_comb begin
        w_count_next = r_count;
        if (i_clear) begin
            w_count_next = '0;
        end else begin
            case ({w_push_ok, w_pop_ok})
                2'b10:   w_count_next = r_count + CNT_W'(1);
                2'b01:   w_count_next = r_count - CNT_W'(1);
                default: w_count_next = r_count;
            endcase
        end
    end

    // Pointer width is exactly log2(DEPTH), so increments wrap modulo DEPTH.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (i_clear) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_push_ok) begin
                r_tail <= r_tail + PTR_W'(1);
            end
            if (w_pop_ok) begin
                r_head <= r_head + PTR_W'(1);
            end
            r_count <= w_count_next;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_tail] <= i_wdata;
        end
    end

    assign o_push_ok    = w_push_ok;
    assign o_rdata      = r_mem[r_head];
    assign o_count      = r_count;
    assign o_count_next = w_count_next;

endmodule
`default_nettype wire

// File: rtl/aes_result_collector.sv
`default_nettype none
// ============================================================================
//  Module  : aes_result_collector
//  Purpose : Captures 128-bit AES result blocks into a FIFO, throttles the
//            core through o_enable, and serializes each block as four 32-bit
//            words (MS word first) on a valid/ready stream.
//  Ports   : clk, reset (async, active-high), i_clear (sync flush)
//            i_data / i_data_valid        - result blocks from the core
//            o_enable                     - core may advance
//            o_word / o_word_valid /
//            i_word_ready / o_last        - output word stream
//            o_level                      - stored blocks incl. the active one
//            o_overflow                   - sticky dropped-block flag
//  Revision: 1.0  initial release
// ============================================================================
module aes_result_collector
    import aes_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int SKID  = 1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [AES_BLOCK_W-1:0]       i_data,
    input  logic                         i_data_valid,
    output logic                         o_enable,
    output logic [AES_WORD_W-1:0]        o_word,
    output logic                         o_word_valid,
    input  logic                         i_word_ready,
    output logic                         o_last,
    output logic [$clog2(DEPTH+1)-1:0]   o_level,
    output logic                         o_overflow,
    input  logic                         i_clear
);

    localparam int               CNT_W          = $clog2(DEPTH + 1);
    // Core may run while (DEPTH - count_next) > SKID, i.e. count_next < limit.
    localparam logic [CNT_W-1:0] c_ENABLE_LIMIT = CNT_W'(DEPTH - SKID);

    logic [AES_BLOCK_W-1:0] w_head;
    logic [CNT_W-1:0]       w_count;
    logic [CNT_W-1:0]       w_count_next;
    logic                   w_push_ok;
    logic                   w_handshake;
    logic                   w_pop;
    word_idx_t              r_idx;
    logic                   r_overflow;
    logic                   r_enable;

    assign w_handshake = o_word_valid & i_word_ready;
    assign w_pop       = w_handshake & (r_idx == c_LAST_WORD);

    aes_result_fifo #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk          (clk),
        .reset        (reset),
        .i_clear      (i_clear),
        .i_push       (i_data_valid),
        .i_wdata      (i_data),
        .i_pop        (w_pop),
        .o_push_ok    (w_push_ok),
        .o_rdata      (w_head),
        .o_count      (w_count),
        .o_count_next (w_count_next)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_idx      <= '0;
            r_overflow <= 1'b0;
            r_enable   <= 1'b1;
        end else if (i_clear) begin
            r_idx      <= '0;
            r_overflow <= 1'b0;
            r_enable   <= 1'b1;
        end else begin
            // Two-bit index wraps from the last word back to 0 on pop.
            if (w_handshake) begin
                r_idx <= r_idx + word_idx_t'(1);
            end
            if (i_data_valid & ~w_push_ok) begin
                r_overflow <= 1'b1;
            end
            r_enable <= (w_count_next < c_ENABLE_LIMIT);
        end
    end

    assign o_word_valid = (w_count != '0);
    assign o_word       = o_word_valid ? block_word(w_head, r_idx) : '0;
    assign o_last       = o_word_valid & (r_idx == c_LAST_WORD);
    assign o_level      = w_count;
    assign o_overflow   = r_overflow;
    assign o_enable     = r_enable;

endmodule
`default_nettype wire

// File: tb/tb_aes_result_collector.sv
`default_nettype none
// ============================================================================
//  Module  : tb_aes_result_collector
//  Purpose : Self-checking bench for aes_result_collector. A queue-based
//            model of the collector is advanced on every clock edge and all
//            outputs are compared against it each cycle; directed scenarios
//            add hand-computed literal expectations.
//  Revision: 1.0  initial release
// ============================================================================
module tb_aes_result_collector;

    localparam int DEPTH = 4;
    localparam int SKID  = 1;
    localparam int LVL_W = $clog2(DEPTH + 1);

    logic             clk = 1'b0;
    logic             reset;
    logic [127:0]     i_data;
    logic             i_data_valid;
    logic             o_enable;
    logic [31:0]      o_word;
    logic             o_word_valid;
    logic             i_word_ready;
    logic             o_last;
    logic [LVL_W-1:0] o_level;
    logic             o_overflow;
    logic             i_clear;

    int checks = 0;
    int errors = 0;

    // Model state: stored blocks in arrival order, current word, flags.
    logic [127:0] mq[$];
    int           midx;
    bit           movf;
    bit           men;

    logic [127:0] blks [6];

    always #5 clk = ~clk;

    aes_result_collector #(
        .DEPTH (DEPTH),
        .SKID  (SKID)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .i_data       (i_data),
        .i_data_valid (i_data_valid),
        .o_enable     (o_enable),
        .o_word       (o_word),
        .o_word_valid (o_word_valid),
        .i_word_ready (i_word_ready),
        .o_last       (o_last),
        .o_level      (o_level),
        .o_overflow   (o_overflow),
        .i_clear      (i_clear)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        midx = 0;
        movf = 1'b0;
        men  = 1'b1;
    endtask

    task automatic model_edge(input bit v, input logic [127:0] d, input bit rdy, input bit clr);
        bit hs, pop, push;
        if (clr) begin
            model_reset();
        end else begin
            hs   = (mq.size() != 0) && rdy;
            pop  = hs && (midx == 3);
            push = v && ((mq.size() < DEPTH) || pop);
            if (v && !push) movf = 1'b1;
            if (hs) begin
                if (midx == 3) begin
                    mq.delete(0);
                    midx = 0;
                end else begin
                    midx++;
                end
            end
            if (push) mq.push_back(d);
            men = (DEPTH - mq.size()) > SKID;
        end
    endtask

    task automatic compare_all();
        logic [127:0] t;
        bit           ev;
        ev = (mq.size() != 0);
        chk("valid",    32'(o_word_valid), 32'(ev));
        chk("level",    32'(o_level),      32'(mq.size()));
        chk("overflow", 32'(o_overflow),   32'(movf));
        chk("enable",   32'(o_enable),     32'(men));
        chk("last",     32'(o_last),       32'(ev && (midx == 3)));
        if (ev) begin
            t = mq[0] >> (32 * (3 - midx));
            chk("word", o_word, t[31:0]);
        end
    endtask

    // Drive inputs for one cycle, advance the model at the edge, compare
    // on the following falling edge.
    task automatic cycle(input bit v, input logic [127:0] d, input bit rdy, input bit clr);
        i_data_valid = v;
        i_data       = d;
        i_word_ready = rdy;
        i_clear      = clr;
        @(posedge clk);
        model_edge(v, d, rdy, clr);
        @(negedge clk);
        compare_all();
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_valid"},    32'(o_word_valid), 32'd0);
        chk({tag, "_level"},    32'(o_level),      32'd0);
        chk({tag, "_overflow"}, 32'(o_overflow),   32'd0);
        chk({tag, "_enable"},   32'(o_enable),     32'd1);
        chk({tag, "_last"},     32'(o_last),       32'd0);
        chk({tag, "_word"},     o_word,            32'd0);
    endtask

    initial begin
        bit           rv, rr, rc;
        logic [127:0] rd;
        int           rp;

        blks[0] = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
        blks[1] = 128'h00112233445566778899aabbccddeeff;
        blks[2] = 128'hdeadbeefcafef00d0123456789abcdef;
        blks[3] = 128'h11111111222222223333333344444444;
        blks[4] = 128'h55555555666666667777777788888888;
        blks[5] = 128'ha5a5a5a55a5a5a5af0f0f0f00f0f0f0f;

        reset        = 1'b1;
        i_data       = '0;
        i_data_valid = 1'b0;
        i_word_ready = 1'b0;
        i_clear      = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        chk_reset_state("rst");
        compare_all();

        // Single block, ready held high.
        cycle(1'b1, blks[0], 1'b1, 1'b0);
        chk("sb_w0", o_word, 32'h69c4e0d8);
        chk("sb_lvl1", 32'(o_level), 32'd1);
        chk("sb_last0", 32'(o_last), 32'd0);
        cycle(1'b0, '0, 1'b1, 1'b0);
        chk("sb_w1", o_word, 32'h6a7b0430);
        cycle(1'b0, '0, 1'b1, 1'b0);
        chk("sb_w2", o_word, 32'hd8cdb780);
        cycle(1'b0, '0, 1'b1, 1'b0);
        chk("sb_w3", o_word, 32'h70b4c55a);
        chk("sb_last1", 32'(o_last), 32'd1);
        cycle(1'b0, '0, 1'b1, 1'b0);
        chk("sb_lvl0", 32'(o_level), 32'd0);
        chk("sb_empty", 32'(o_word_valid), 32'd0);

        // Backpressure and overflow.
        cycle(1'b1, blks[0], 1'b0, 1'b0);
        cycle(1'b1, blks[1], 1'b0, 1'b0);
        chk("bp_en_at2", 32'(o_enable), 32'd1);
        cycle(1'b1, blks[2], 1'b0, 1'b0);
        chk("bp_lvl3", 32'(o_level), 32'd3);
        chk("bp_en_at3", 32'(o_enable), 32'd0);
        cycle(1'b1, blks[3], 1'b0, 1'b0);
        chk("bp_lvl4", 32'(o_level), 32'd4);
        chk("bp_ovf0", 32'(o_overflow), 32'd0);
        cycle(1'b1, blks[4], 1'b0, 1'b0);
        chk("ov_lvl4", 32'(o_level), 32'd4);
        chk("ov_ovf1", 32'(o_overflow), 32'd1);
        chk("ov_head", o_word, 32'h69c4e0d8);
        repeat (16) cycle(1'b0, '0, 1'b1, 1'b0);
        chk("ov_drained", 32'(o_level), 32'd0);
        chk("ov_sticky", 32'(o_overflow), 32'd1);

        // Full with simultaneous push and pop.
        cycle(1'b0, '0, 1'b0, 1'b1);
        chk("clr_ovf", 32'(o_overflow), 32'd0);
        for (int i = 0; i < 4; i++) cycle(1'b1, blks[i], 1'b0, 1'b0);
        repeat (3) cycle(1'b0, '0, 1'b1, 1'b0);
        chk("fp_last", 32'(o_last), 32'd1);
        cycle(1'b1, blks[5], 1'b1, 1'b0);
        chk("fp_lvl4", 32'(o_level), 32'd4);
        chk("fp_ovf0", 32'(o_overflow), 32'd0);
        chk("fp_head", o_word, 32'h00112233);
        repeat (16) cycle(1'b0, '0, 1'b1, 1'b0);

        // Stall mid-block.
        cycle(1'b1, blks[0], 1'b1, 1'b0);
        cycle(1'b0, '0, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            cycle(1'b0, '0, 1'b0, 1'b0);
            chk("st_hold", o_word, 32'h6a7b0430);
            chk("st_last", 32'(o_last), 32'd0);
        end
        cycle(1'b0, '0, 1'b1, 1'b0);
        chk("st_resume", o_word, 32'hd8cdb780);
        repeat (2) cycle(1'b0, '0, 1'b1, 1'b0);

        // Synchronous clear after word 2 with two blocks stored.
        cycle(1'b1, blks[0], 1'b0, 1'b0);
        cycle(1'b1, blks[1], 1'b1, 1'b0);
        cycle(1'b0, '0, 1'b1, 1'b0);
        chk("cl_w2", o_word, 32'hd8cdb780);
        cycle(1'b1, blks[2], 1'b1, 1'b1);
        chk_reset_state("clr");

        // Asynchronous reset mid-block, checked before the next edge.
        cycle(1'b1, blks[0], 1'b0, 1'b0);
        cycle(1'b1, blks[1], 1'b1, 1'b0);
        cycle(1'b0, '0, 1'b1, 1'b0);
        i_data_valid = 1'b0;
        i_word_ready = 1'b0;
        #1 reset = 1'b1;
        #1 chk_reset_state("arst");
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        compare_all();

        // Randomized traffic with alternating drain pressure.
        for (int n = 0; n < 3000; n++) begin
            rp = ((n / 100) % 2 == 0) ? 25 : 85;
            rv = ($urandom_range(0, 1) == 1);
            rr = ($urandom_range(0, 99) < rp);
            rc = ($urandom_range(0, 79) == 0);
            rd = {$urandom, $urandom, $urandom, $urandom};
            cycle(rv, rd, rr, rc);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
